// File: rtl/cordic_phase_gen_if.sv
// rtl/cordic_phase_gen_if.sv - command and angle-stream bundle between the burst requester and cordic_phase_gen
interface cordic_phase_gen_if #(
    parameter int Z_WIDTH   = 12,
    parameter int CNT_WIDTH = 16
);
    logic                  start;
    logic                  abort;
    logic signed [Z_WIDTH:0] phase_init;
    logic signed [Z_WIDTH:0] phase_step;
    logic [CNT_WIDTH-1:0]  count;
    logic signed [Z_WIDTH:0] z0;
    logic                  z0_valid;
    logic                  out_valid;
    logic                  busy;
    logic                  done;

    modport master (
        output start, abort, phase_init, phase_step, count,
        input  z0, z0_valid, out_valid, busy, done
    );

    modport slave (
        input  start, abort, phase_init, phase_step, count,
        output z0, z0_valid, out_valid, busy, done
    );
endinterface

// File: rtl/cordic_phase_gen.sv
// rtl/cordic_phase_gen.sv - burst phase accumulator for the CORDIC z0 port; CORDIC_PHASEGEN_FREERUN_EN makes count==0 free-run
module cordic_phase_gen #(
    parameter int Z_WIDTH   = 12,
    parameter int N_STAGES  = 10,
    parameter int CNT_WIDTH = 16
) (
    input  logic              clk,
    input  logic              reset,
    cordic_phase_gen_if.slave bus
);
    localparam int ZW = Z_WIDTH + 1;
    localparam int SW = Z_WIDTH + 2;
    localparam logic signed [SW-1:0] WRAP_HI = SW'(2879);
    localparam logic signed [SW-1:0] WRAP_LO = SW'(-2880);
    localparam logic signed [SW-1:0] SPAN    = SW'(5760);
    localparam logic signed [ZW-1:0] STEP_HI = ZW'(2880);
    localparam logic signed [ZW-1:0] STEP_LO = ZW'(-2880);
    localparam logic [N_STAGES-1:0]  DL_LAST = N_STAGES'(1) << (N_STAGES - 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t                 state;
    logic signed [ZW-1:0]   z0_r;
    logic signed [ZW-1:0]   step_r;
    logic [CNT_WIDTH-1:0]   remaining;
    logic [N_STAGES-1:0]    dl;
    logic                   z0_valid_r;
    logic                   busy_r;
    logic                   done_r;
    logic signed [SW-1:0]   sum;
    logic                   launch;
    logic                   run_last;
    logic                   cnt_en;

    // Step is clamped to half a turn, so a single correction always lands back in range.
    function automatic logic signed [ZW-1:0] wrap(input logic signed [SW-1:0] s);
        logic signed [SW-1:0] r;
        r = s;
        if (s > WRAP_HI)
            r = s - SPAN;
        else if (s < WRAP_LO)
            r = s + SPAN;
        return r[ZW-1:0];
    endfunction

    function automatic logic signed [ZW-1:0] clamp_step(input logic signed [ZW-1:0] s);
        if (s > STEP_HI)
            return STEP_HI;
        if (s < STEP_LO)
            return STEP_LO;
        return s;
    endfunction

    assign sum = {z0_r[ZW-1], z0_r} + {step_r[ZW-1], step_r};

`ifdef CORDIC_PHASEGEN_FREERUN_EN
    logic free_run;
    assign run_last = !free_run && (remaining == '0);
    assign cnt_en   = !free_run;
`else
    assign run_last = (remaining == '0);
    assign cnt_en   = 1'b1;
`endif

    always_comb begin
        launch = 1'b0;
        if (state == IDLE && bus.start && !done_r && !bus.abort) begin
`ifdef CORDIC_PHASEGEN_FREERUN_EN
            launch = 1'b1;
`else
            launch = (bus.count != '0);
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            z0_r       <= '0;
            step_r     <= '0;
            remaining  <= '0;
            dl         <= '0;
            z0_valid_r <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
`ifdef CORDIC_PHASEGEN_FREERUN_EN
            free_run   <= 1'b0;
`endif
        end else begin
            done_r <= 1'b0;
            dl     <= (dl << 1) | N_STAGES'(z0_valid_r);
            if (bus.abort) begin
                state      <= IDLE;
                z0_valid_r <= 1'b0;
                busy_r     <= 1'b0;
                dl         <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (launch) begin
                            state      <= RUN;
                            z0_r       <= wrap({bus.phase_init[ZW-1], bus.phase_init});
                            step_r     <= clamp_step(bus.phase_step);
                            remaining  <= bus.count - CNT_WIDTH'(1);
                            z0_valid_r <= 1'b1;
                            busy_r     <= 1'b1;
`ifdef CORDIC_PHASEGEN_FREERUN_EN
                            free_run   <= (bus.count == '0);
`endif
                        end else if (bus.start && !done_r) begin
                            done_r <= 1'b1;
                        end
                    end
                    RUN: begin
                        if (run_last) begin
                            state      <= DRAIN;
                            z0_valid_r <= 1'b0;
                        end else begin
                            z0_r <= wrap(sum);
                            if (cnt_en)
                                remaining <= remaining - CNT_WIDTH'(1);
                        end
                    end
                    DRAIN: begin
                        // Only the final sample left, sitting at the delay-line output.
                        if ((dl & ~DL_LAST) == '0) begin
                            state  <= IDLE;
                            busy_r <= 1'b0;
                            done_r <= 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign bus.z0        = z0_r;
    assign bus.z0_valid  = z0_valid_r;
    assign bus.out_valid = dl[N_STAGES-1];
    assign bus.busy      = busy_r;
    assign bus.done      = done_r;
endmodule

// File: tb/tb_cordic_phase_gen.sv
// tb/tb_cordic_phase_gen.sv - scoreboard bench for cordic_phase_gen against an arithmetic reference model
module tb_cordic_phase_gen;
    localparam int ZW = 12;
    localparam int NS = 10;
    localparam int CW = 16;

    typedef struct {
        int cyc;
        int val;
    } ent_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    ent_t exp_z[$];
    int   exp_ov[$];
    int   exp_done[$];
    int   busy_lo = 0;
    int   busy_hi = -1;
    int   done_cyc = -1;

    cordic_phase_gen_if #(.Z_WIDTH(ZW), .CNT_WIDTH(CW)) bus();

    cordic_phase_gen #(.Z_WIDTH(ZW), .N_STAGES(NS), .CNT_WIDTH(CW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int wrapm(int x);
        return ((x + 2880) % 5760 + 5760) % 5760 - 2880;
    endfunction

    function automatic int clampm(int s);
        return (s > 2880) ? 2880 : ((s < -2880) ? -2880 : s);
    endfunction

    function automatic bit model_busy(int c);
        return (c >= busy_lo) && (c <= busy_hi);
    endfunction

    function automatic void check(string name, int got, int want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0d want=%0d", name, cyc, got, want);
        end
    endfunction

    function automatic void fail(string name, int got, int want);
        checks++;
        errors++;
        $display("FAIL %s cyc=%0d got=%0d want=%0d", name, cyc, got, want);
    endfunction

    function automatic void push_samples(int t1, int n, int init, int step);
        ent_t e;
        for (int i = 0; i < n; i++) begin
            e.cyc = t1 + i;
            e.val = wrapm(init + i * clampm(step));
            exp_z.push_back(e);
            exp_ov.push_back(t1 + NS + i);
        end
    endfunction

    // Start driven during cycle c is taken at the next edge; outputs seen from cycle c+1.
    function automatic void model_start(int c, int init, int step, int cnt);
        int t1;
        if (model_busy(c) || c == done_cyc)
            return;
        t1 = c + 1;
        if (cnt == 0) begin
`ifdef CORDIC_PHASEGEN_FREERUN_EN
            push_samples(t1, 64, init, step);
            busy_lo = t1;
            busy_hi = 1 << 30;
`else
            exp_done.push_back(t1);
            done_cyc = t1;
`endif
            return;
        end
        push_samples(t1, cnt, init, step);
        busy_lo  = t1;
        busy_hi  = t1 + cnt + NS - 1;
        done_cyc = t1 + cnt + NS;
        exp_done.push_back(done_cyc);
    endfunction

    function automatic void model_purge(int c);
        while (exp_z.size() > 0 && exp_z[$].cyc > c) void'(exp_z.pop_back());
        while (exp_ov.size() > 0 && exp_ov[$] > c) void'(exp_ov.pop_back());
        while (exp_done.size() > 0 && exp_done[$] > c) void'(exp_done.pop_back());
        if (busy_hi > c) busy_hi = c;
        if (done_cyc > c) done_cyc = -1;
    endfunction

    always @(negedge clk) begin
        int zv;
        while (exp_z.size() > 0 && exp_z[0].cyc < cyc) begin
            fail("missed_z0", 0, exp_z[0].val);
            void'(exp_z.pop_front());
        end
        while (exp_ov.size() > 0 && exp_ov[0] < cyc) begin
            fail("missed_out_valid", 0, 1);
            void'(exp_ov.pop_front());
        end
        while (exp_done.size() > 0 && exp_done[0] < cyc) begin
            fail("missed_done", 0, 1);
            void'(exp_done.pop_front());
        end
        if (bus.z0_valid) begin
            zv = int'(bus.z0);
            if (exp_z.size() > 0 && exp_z[0].cyc == cyc) begin
                check("z0", zv, exp_z[0].val);
                void'(exp_z.pop_front());
            end else begin
                fail("unexpected_z0_valid", 1, 0);
            end
        end
        if (bus.out_valid) begin
            if (exp_ov.size() > 0 && exp_ov[0] == cyc) begin
                check("out_valid", 1, 1 - int'(exp_ov.size() == 0));
                void'(exp_ov.pop_front());
            end else begin
                fail("unexpected_out_valid", 1, 0);
            end
        end
        if (bus.done) begin
            if (exp_done.size() > 0 && exp_done[0] == cyc)
                void'(exp_done.pop_front());
            else
                fail("unexpected_done", 1, 0);
        end
        check("busy", int'(bus.busy), int'(model_busy(cyc)));
    end

    task automatic cycle_in(bit s, bit a, bit r, int init, int step, int cnt);
        bus.start      = s;
        bus.abort      = a;
        reset          = r;
        bus.phase_init = (ZW + 1)'(init);
        bus.phase_step = (ZW + 1)'(step);
        bus.count      = CW'(cnt);
        if (r || a)
            model_purge(cyc);
        else if (s)
            model_start(cyc, init, step, cnt);
        @(negedge clk);
        bus.start = 1'b0;
        bus.abort = 1'b0;
        reset     = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((model_busy(cyc) || cyc <= done_cyc) && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (n >= 400) fail("timeout_idle", n, 400);
        @(negedge clk);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog cyc=%0d got=running want=finished", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int init, step, cnt, gap;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        bus.phase_init = '0;
        bus.phase_step = '0;
        bus.count = '0;
        repeat (3) @(negedge clk);
        check("rst_z0", int'(bus.z0), 0);
        check("rst_z0_valid", int'(bus.z0_valid), 0);
        check("rst_out_valid", int'(bus.out_valid), 0);
        check("rst_busy", int'(bus.busy), 0);
        check("rst_done", int'(bus.done), 0);
        reset = 1'b0;
        @(negedge clk);

        cycle_in(1, 0, 0, 0, 160, 4);       wait_idle();
        cycle_in(1, 0, 0, 2800, 160, 3);    wait_idle();
        cycle_in(1, 0, 0, -2850, -100, 2);  wait_idle();
        cycle_in(1, 0, 0, 0, 4000, 3);      wait_idle();
        cycle_in(1, 0, 0, 4000, -4000, 5);  wait_idle();

`ifdef CORDIC_PHASEGEN_FREERUN_EN
        cycle_in(1, 0, 0, 100, 37, 0);
        repeat (20) @(negedge clk);
        cycle_in(0, 1, 0, 0, 0, 0);
        wait_idle();
`else
        cycle_in(1, 0, 0, 100, 37, 0);
        wait_idle();
`endif

        cycle_in(1, 0, 0, 500, -300, 8);
        cycle_in(0, 0, 0, 0, 0, 0);
        cycle_in(0, 0, 0, 0, 0, 0);
        cycle_in(0, 1, 0, 0, 0, 0);
        check("abort_z0_valid", int'(bus.z0_valid), 0);
        check("abort_out_valid", int'(bus.out_valid), 0);
        check("abort_busy", int'(bus.busy), 0);
        @(negedge clk);
        cycle_in(1, 0, 0, -1000, 250, 5);   wait_idle();

        cycle_in(1, 0, 0, 10, 20, 6);
        repeat (2) @(negedge clk);
        cycle_in(1, 0, 0, 999, 1, 9);
        repeat (8) @(negedge clk);
        cycle_in(1, 0, 0, 777, 2, 3);
        wait_idle();

        cycle_in(1, 0, 0, 40, 40, 2);
        for (int i = 0; i < 100 && cyc < done_cyc; i++) @(negedge clk);
        cycle_in(1, 0, 0, 55, 5, 4);
        wait_idle();

        cycle_in(1, 1, 0, 300, 30, 5);
        repeat (NS + 4) @(negedge clk);

        cycle_in(1, 0, 0, 700, 100, 3);
        repeat (6) @(negedge clk);
        cycle_in(1, 1, 1, 1, 1, 4);
        check("rst2_z0", int'(bus.z0), 0);
        check("rst2_z0_valid", int'(bus.z0_valid), 0);
        check("rst2_out_valid", int'(bus.out_valid), 0);
        check("rst2_busy", int'(bus.busy), 0);
        check("rst2_done", int'(bus.done), 0);
        wait_idle();

        for (int k = 0; k < 40; k++) begin
            init = int'($urandom_range(8191)) - 4096;
            step = int'($urandom_range(8191)) - 4096;
            cnt  = int'($urandom_range(12, 1));
            cycle_in(1, 0, 0, init, step, cnt);
            if ($urandom_range(3) == 0) begin
                gap = int'($urandom_range(cnt + NS + 2));
                repeat (gap) @(negedge clk);
                cycle_in(0, 1, 0, 0, 0, 0);
            end else if ($urandom_range(2) == 0) begin
                repeat ($urandom_range(cnt + NS)) @(negedge clk);
                cycle_in(1, 0, 0, step, init, cnt + 1);
            end
            wait_idle();
            repeat ($urandom_range(2)) @(negedge clk);
        end

        wait_idle();
        repeat (NS + 3) @(negedge clk);
        check("leftover_expected", exp_z.size() + exp_ov.size() + exp_done.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
